// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: FETCH/EXEC handshake with next-PC selection.
// Optional PC_TRAP_EN macro enables misaligned-target trapping to TRAP_VECTOR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_imem_ready,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jal,
  input  logic [31:0] i_jal_target,
  input  logic        i_jalr,
  input  logic [31:0] i_jalr_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  output logic        o_instr_valid,
  output logic        o_trap,
  output logic [31:0] o_bad_addr,
  output logic [31:0] o_retire_count
);

  typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_bad_addr, w_bad_addr_nxt;
  logic [31:0] r_retire_count, w_retire_count_nxt;
  logic        r_trap, w_trap_nxt;
  logic [31:0] w_target;
  logic [31:0] w_load_pc;
  logic        w_misaligned;

  // Next-PC candidate: jalr > jal > branch > sequential
  always_comb begin
    w_target = i_pc_plus4;
    if (i_jalr)              w_target = i_jalr_target & ~32'h0000_0001;
    else if (i_jal)          w_target = i_jal_target;
    else if (i_branch_taken) w_target = i_branch_target;
  end

`ifdef PC_TRAP_EN
  assign w_misaligned = (i_jalr | i_jal | i_branch_taken) && (w_target[1:0] != 2'b00);
  assign w_load_pc    = w_target;
`else
  assign w_misaligned = 1'b0;
  assign w_load_pc    = w_target & ~32'h0000_0003;
`endif

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_trap_nxt         = 1'b0;
    w_bad_addr_nxt     = r_bad_addr;
    w_retire_count_nxt = r_retire_count;
    case (r_state)
      S_FETCH: begin
        if (i_imem_ready) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!i_stall) begin
          w_state_nxt = S_FETCH;
          if (w_misaligned) begin
            w_pc_nxt       = TRAP_VECTOR;
            w_trap_nxt     = 1'b1;
            w_bad_addr_nxt = w_target;
          end else begin
            w_pc_nxt           = w_load_pc;
            w_retire_count_nxt = r_retire_count + 32'd1;
          end
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_VECTOR;
      r_trap         <= 1'b0;
      r_bad_addr     <= 32'h0000_0000;
      r_retire_count <= 32'h0000_0000;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_trap         <= w_trap_nxt;
      r_bad_addr     <= w_bad_addr_nxt;
      r_retire_count <= w_retire_count_nxt;
    end
  end

  // Handshake strobes decode straight from state; reset masks the request
  assign o_imem_req     = (r_state == S_FETCH) && !i_rst;
  assign o_instr_valid  = (r_state == S_EXEC);
  assign o_pc           = r_pc;
  assign o_imem_addr    = r_pc;
  assign o_trap         = r_trap;
  assign o_bad_addr     = r_bad_addr;
  assign o_retire_count = r_retire_count;

endmodule
